// File: rtl/seg_scan_if.sv
// Bus between a multiplexed seven-segment driver (master) and the scan decoder (slave):
// the active-low segment/anode lines plus the decoded per-digit results.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    update;
    logic [IDX_W-1:0]        update_idx;
    logic                    frame_done;
    logic                    sel_err;

    modport master (
        output seg_n, an_n,
        input  digits, digit_valid, digit_blank, digit_err,
        input  update, update_idx, frame_done, sel_err
    );

    modport slave (
        input  seg_n, an_n,
        output digits, digit_valid, digit_blank, digit_err,
        output update, update_idx, frame_done, sel_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Reconstructs the decimal value of each digit on a time-multiplexed, active-low
// seven-segment bus once a segment/anode pair has been stable for STABLE_CYCLES samples.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int IDX_W         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Packs {bcd[3:0], valid, blank, err}; exactly one flag is ever set.
    function automatic logic [6:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = {4'd0, 3'b100};
            7'h79:   decode_seg = {4'd1, 3'b100};
            7'h24:   decode_seg = {4'd2, 3'b100};
            7'h30:   decode_seg = {4'd3, 3'b100};
            7'h19:   decode_seg = {4'd4, 3'b100};
            7'h12:   decode_seg = {4'd5, 3'b100};
            7'h02:   decode_seg = {4'd6, 3'b100};
            7'h78:   decode_seg = {4'd7, 3'b100};
            7'h00:   decode_seg = {4'd8, 3'b100};
            7'h10:   decode_seg = {4'd9, 3'b100};
            7'h7F:   decode_seg = {4'hF, 3'b010};
            default: decode_seg = {4'hF, 3'b001};
        endcase
    endfunction

    logic [6:0]              r_seg_q, r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_an_q, r_an_prev;
    state_t                  r_state, w_state_next;
    logic [7:0]              r_cnt, w_cnt_next;
    logic                    w_capture;
    logic [NUM_DIGITS-1:0]   r_seen, w_seen_next;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid, r_blank, r_err;
    logic                    r_update, r_frame_done, r_sel_err, r_illegal_prev;
    logic [IDX_W-1:0]        r_update_idx, w_idx;
    logic [3:0]              w_low_cnt;
    logic                    w_legal, w_illegal, w_changed;
    logic [6:0]              w_dec;

    // Select decode: count low anode bits and remember the position of the last one.
    always_comb begin
        w_low_cnt = 4'd0;
        w_idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) begin
                w_low_cnt = w_low_cnt + 4'd1;
                w_idx     = IDX_W'(i);
            end else begin
                w_low_cnt = w_low_cnt;
            end
        end
        w_legal     = (w_low_cnt == 4'd1);
        w_illegal   = (w_low_cnt > 4'd1);
        w_changed   = (r_seg_q != r_seg_prev) || (r_an_q != r_an_prev);
        w_dec       = decode_seg(r_seg_q);
        w_seen_next = r_seen | (NUM_DIGITS'(1) << w_idx);
    end

    // Input stage plus the previous sample used for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q    <= 7'h7F;
            r_an_q     <= {NUM_DIGITS{1'b1}};
            r_seg_prev <= 7'h7F;
            r_an_prev  <= {NUM_DIGITS{1'b1}};
        end else begin
            r_seg_q    <= bus.seg_n;
            r_an_q     <= bus.an_n;
            r_seg_prev <= r_seg_q;
            r_an_prev  <= r_an_q;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a pair change always wins over a pending capture.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_legal) w_state_next = S_TRACK;
                else         w_state_next = S_IDLE;
            end
            S_TRACK: begin
                if (!w_legal)                  w_state_next = S_IDLE;
                else if (w_changed)            w_state_next = S_TRACK;
                else if (r_cnt == STABLE_LAST) w_state_next = S_HOLD;
                else                           w_state_next = S_TRACK;
            end
            S_HOLD: begin
                if (!w_legal)       w_state_next = S_IDLE;
                else if (w_changed) w_state_next = S_TRACK;
                else                w_state_next = S_HOLD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counter update and capture strobe.
    always_comb begin
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_legal) w_cnt_next = 8'd1;
                else         w_cnt_next = 8'd0;
            end
            S_TRACK: begin
                if (!w_legal) begin
                    w_cnt_next = 8'd0;
                end else if (w_changed) begin
                    w_cnt_next = 8'd1;
                end else if (r_cnt == STABLE_LAST) begin
                    w_cnt_next = r_cnt + 8'd1;
                    w_capture  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (!w_legal)       w_cnt_next = 8'd0;
                else if (w_changed) w_cnt_next = 8'd1;
                else                w_cnt_next = r_cnt;
            end
            default: w_cnt_next = 8'd0;
        endcase
    end

    // Captured digit storage, frame tracking and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits       <= {NUM_DIGITS{4'hF}};
            r_valid        <= '0;
            r_blank        <= '0;
            r_err          <= '0;
            r_update       <= 1'b0;
            r_update_idx   <= '0;
            r_frame_done   <= 1'b0;
            r_seen         <= '0;
            r_sel_err      <= 1'b0;
            r_illegal_prev <= 1'b0;
        end else begin
            r_update       <= w_capture;
            r_sel_err      <= w_illegal && !r_illegal_prev;
            r_illegal_prev <= w_illegal;
            r_frame_done   <= 1'b0;
            if (w_capture) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_dec[6:3];
                r_valid[w_idx] <= w_dec[2];
                r_blank[w_idx] <= w_dec[1];
                r_err[w_idx]   <= w_dec[0];
                r_update_idx   <= w_idx;
                // The completing capture starts the next frame empty.
                if (w_seen_next == ALL_SEEN) begin
                    r_frame_done <= 1'b1;
                    r_seen       <= '0;
                end else begin
                    r_seen       <= w_seen_next;
                end
            end else begin
                r_update_idx <= r_update_idx;
            end
        end
    end

    assign bus.digits      = r_digits;
    assign bus.digit_valid = r_valid;
    assign bus.digit_blank = r_blank;
    assign bus.digit_err   = r_err;
    assign bus.update      = r_update;
    assign bus.update_idx  = r_update_idx;
    assign bus.frame_done  = r_frame_done;
    assign bus.sel_err     = r_sel_err;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES=4 and four digits.
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    int         h_upd, h_upd_edge, h_fd, h_fd_edge, h_se;
    logic [1:0] h_upd_idx;

    seg_scan_if #(.NUM_DIGITS(4), .IDX_W(2)) bus ();

    seg_scan_decoder #(.NUM_DIGITS(4), .IDX_W(2), .STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive the pair, observe n rising edges, end on the next negedge.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_n  = an;
        bus.seg_n = seg;
        h_upd = 0; h_upd_edge = 0; h_upd_idx = 2'd0;
        h_fd = 0; h_fd_edge = 0; h_se = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (bus.update === 1'b1) begin
                h_upd++;
                h_upd_edge = k;
                h_upd_idx  = bus.update_idx;
            end
            if (bus.frame_done === 1'b1) begin
                h_fd++;
                h_fd_edge = k;
            end
            if (bus.sel_err === 1'b1) h_se++;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_digits"}, bus.digits, 32'hFFFF);
        chk({tag, "_valid"},  bus.digit_valid, 32'h0);
        chk({tag, "_blank"},  bus.digit_blank, 32'h0);
        chk({tag, "_err"},    bus.digit_err, 32'h0);
        chk({tag, "_update"}, bus.update, 32'h0);
        chk({tag, "_uidx"},   bus.update_idx, 32'h0);
        chk({tag, "_frame"},  bus.frame_done, 32'h0);
        chk({tag, "_selerr"}, bus.sel_err, 32'h0);
    endtask

    initial begin
        logic [6:0] pats [4];
        logic [3:0] an_v;
        pats = '{7'h24, 7'h30, 7'h19, 7'h12};
        bus.an_n  = 4'b1111;
        bus.seg_n = 7'h7F;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Single digit 0 capture at edge 5 and no re-capture
        hold(4'b1110, 7'h40, 6);
        chk("t1_upd_cnt",  h_upd, 32'd1);
        chk("t1_upd_edge", h_upd_edge, 32'd5);
        chk("t1_upd_idx",  h_upd_idx, 32'd0);
        chk("t1_digits",   bus.digits, 32'hFFF0);
        chk("t1_valid",    bus.digit_valid, 32'h1);

        // Scan of four digits; frame completes on digit 3
        for (int d = 0; d < 4; d++) begin
            an_v = 4'b0001 << d;
            hold(~an_v, pats[d], 6);
            chk("t2_upd_cnt",  h_upd, 32'd1);
            chk("t2_upd_edge", h_upd_edge, 32'd5);
            chk("t2_upd_idx",  h_upd_idx, 32'(d));
            chk("t2_fd_cnt",   h_fd, (d == 3) ? 32'd1 : 32'd0);
            chk("t2_fd_edge",  h_fd_edge, (d == 3) ? 32'd5 : 32'd0);
        end
        chk("t2_digits", bus.digits, 32'h5432);
        chk("t2_valid",  bus.digit_valid, 32'hF);

        // Digit 1 held too briefly, then digit 2
        hold(4'b1101, 7'h40, 3);
        chk("t3_short_upd", h_upd, 32'd0);
        hold(4'b1011, 7'h02, 6);
        chk("t3_upd_cnt",  h_upd, 32'd1);
        chk("t3_upd_edge", h_upd_edge, 32'd5);
        chk("t3_upd_idx",  h_upd_idx, 32'd2);
        chk("t3_digits",   bus.digits, 32'h5632);
        chk("t3_valid",    bus.digit_valid, 32'hF);

        // Blank on digit 2, unrecognised pattern on digit 3
        hold(4'b1011, 7'h7F, 6);
        chk("t4_blank_upd", h_upd, 32'd1);
        hold(4'b0111, 7'h55, 6);
        chk("t4_err_upd", h_upd, 32'd1);
        chk("t4_err_idx", h_upd_idx, 32'd3);
        chk("t4_digits",  bus.digits, 32'hFF32);
        chk("t4_valid",   bus.digit_valid, 32'h3);
        chk("t4_blank",   bus.digit_blank, 32'h4);
        chk("t4_err",     bus.digit_err, 32'h8);

        // Illegal select: one sel_err pulse, no capture, then recovery from IDLE
        hold(4'b1100, 7'h10, 8);
        chk("t5_selerr_cnt", h_se, 32'd1);
        chk("t5_ill_upd",    h_upd, 32'd0);
        hold(4'b1101, 7'h10, 6);
        chk("t5_upd_edge", h_upd_edge, 32'd5);
        chk("t5_upd_idx",  h_upd_idx, 32'd1);
        chk("t5_no_selerr", h_se, 32'd0);
        chk("t5_no_fd",    h_fd, 32'd0);
        chk("t5_digits",   bus.digits, 32'hFF92);
        hold(4'b1110, 7'h00, 6);
        chk("t5_fd_cnt",   h_fd, 32'd1);
        chk("t5_fd_edge",  h_fd_edge, 32'd5);
        chk("t5_digits8",  bus.digits, 32'hFF98);
        chk("t5_valid",    bus.digit_valid, 32'h3);
        hold(4'b1010, 7'h10, 3);
        chk("t5_rearm_selerr", h_se, 32'd1);

        // Reset while tracking with counter at 2
        hold(4'b1110, 7'h79, 3);
        chk("t6_pre_upd", h_upd, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        hold(4'b1110, 7'h79, 6);
        chk("t6_upd_cnt",  h_upd, 32'd1);
        chk("t6_upd_edge", h_upd_edge, 32'd5);
        chk("t6_fd_cnt",   h_fd, 32'd0);
        chk("t6_digits",   bus.digits, 32'hFFF1);
        chk("t6_valid",    bus.digit_valid, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
